// File: rtl/file_write_module.sv
// file_write_module: prescaled START..END sequence generator with optional BCD digits (FILE_WRITE_BCD_EN)
module file_write_module #(
  parameter int unsigned START = 1,
  parameter int unsigned END   = 30,
  parameter int unsigned STEP  = 1,
  parameter int unsigned DIV   = 1,
  parameter bit          WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] count,
  output logic       valid,
  output logic       done,
  output logic [3:0] count_tens,
  output logic [3:0] count_ones
);
  if (START > END) begin : g_bad_range
    $error("file_write_module: START must not exceed END");
  end
  if (END > 255) begin : g_bad_end
    $error("file_write_module: END must fit in 8 bits");
  end
  if (STEP == 0 || STEP > 255) begin : g_bad_step
    $error("file_write_module: STEP must be 1..255");
  end
  if (DIV == 0 || DIV > 65535) begin : g_bad_div
    $error("file_write_module: DIV must be 1..65535");
  end
  logic [15:0] div_cnt;
  logic        adv;
  logic [8:0]  nxt;
  logic        at_end;
  logic        hold;
  logic [7:0]  count_d;
  assign adv    = div_cnt == 16'(DIV - 1);
  assign nxt    = {1'b0, count} + 9'(STEP);
  assign at_end = count == 8'(END);
  assign hold   = at_end && !WRAP;
  // next value: hold, wrap to START, step, or clamp to END so END is always emitted
  always_comb count_d = (!adv || hold) ? count : at_end ? 8'(START) : (nxt <= 9'(END)) ? nxt[7:0] : 8'(END);
  // prescaler, sequence register and registered strobes; done is a wrap pulse or an END level
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      count   <= 8'(START);
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      div_cnt <= adv ? '0 : div_cnt + 16'd1;
      count   <= count_d;
      valid   <= adv && !hold;
      done    <= WRAP ? (adv && at_end) : (count_d == 8'(END));
    end
  end
`ifdef FILE_WRITE_BCD_EN
  // digits saturate to 99 above two-digit range
  always_comb begin
    count_tens = (count > 8'd99) ? 4'd9 : 4'(count / 8'd10);
    count_ones = (count > 8'd99) ? 4'd9 : 4'(count % 8'd10);
  end
`else
  assign count_tens = 4'h0;
  assign count_ones = 4'h0;
`endif
endmodule

// File: tb/tb_file_write_module.sv
// tb_file_write_module: directed checks of sweep, clamp, hold/prescale, mid-run reset and BCD
module tb_file_write_module;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [7:0] c0, c1, c2, c3;
  logic v0, v1, v2, v3, d0, d1, d2, d3;
  logic [3:0] t0, o0, t1, o1, t2, o2, t3, o3;

  always #5 clk = ~clk;

  file_write_module u0 (.clk(clk), .rst(rst), .count(c0), .valid(v0), .done(d0), .count_tens(t0), .count_ones(o0));
  file_write_module #(.STEP(4)) u1 (.clk(clk), .rst(rst), .count(c1), .valid(v1), .done(d1), .count_tens(t1), .count_ones(o1));
  file_write_module #(.WRAP(1'b0), .DIV(3)) u2 (.clk(clk), .rst(rst), .count(c2), .valid(v2), .done(d2), .count_tens(t2), .count_ones(o2));
  file_write_module #(.END(120), .STEP(10)) u3 (.clk(clk), .rst(rst), .count(c3), .valid(v3), .done(d3), .count_tens(t3), .count_ones(o3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] et, eo;
    rst = 1'b1;
    tick();
    tick();
`ifdef FILE_WRITE_BCD_EN
    et = 4'd0; eo = 4'd1;
`else
    et = 4'd0; eo = 4'd0;
`endif
    checks++; if (c0 !== 8'd1) begin failures++; $display("FAIL reset_count got=%0d exp=1", c0); end
    checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", v0); end
    checks++; if (d0 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", d0); end
    checks++; if (t0 !== et || o0 !== eo) begin failures++; $display("FAIL reset_bcd got=%0d/%0d exp=%0d/%0d", t0, o0, et, eo); end
    checks++; if (c2 !== 8'd1 || d2 !== 1'b0 || v2 !== 1'b0) begin failures++; $display("FAIL reset_u2 got=%0d/%b/%b exp=1/0/0", c2, v2, d2); end
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    logic [7:0] ec;
    logic [3:0] et, eo;
    do_reset();
    for (int k = 1; k <= 31; k++) begin
      tick();
      ec = (k <= 29) ? 8'(1 + k) : (k == 30) ? 8'd1 : 8'd2;
      checks++; if (c0 !== ec) begin failures++; $display("FAIL sweep_count k=%0d got=%0d exp=%0d", k, c0, ec); end
      checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL sweep_valid k=%0d got=%b exp=1", k, v0); end
      checks++; if (d0 !== (k == 30)) begin failures++; $display("FAIL sweep_done k=%0d got=%b exp=%b", k, d0, k == 30); end
      if (k == 28) begin
`ifdef FILE_WRITE_BCD_EN
        et = 4'd2; eo = 4'd9;
`else
        et = 4'd0; eo = 4'd0;
`endif
        checks++; if (t0 !== et || o0 !== eo) begin failures++; $display("FAIL bcd_29 got=%0d/%0d exp=%0d/%0d", t0, o0, et, eo); end
      end
    end
  endtask

  task automatic test_clamp;
    logic [7:0] exp_seq [9] = '{8'd5, 8'd9, 8'd13, 8'd17, 8'd21, 8'd25, 8'd29, 8'd30, 8'd1};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      checks++; if (c1 !== exp_seq[k]) begin failures++; $display("FAIL clamp_count k=%0d got=%0d exp=%0d", k, c1, exp_seq[k]); end
      checks++; if (d1 !== (k == 8)) begin failures++; $display("FAIL clamp_done k=%0d got=%b exp=%b", k, d1, k == 8); end
    end
  endtask

  task automatic test_hold_prescale;
    logic [7:0] ec;
    logic ev;
    do_reset();
    for (int k = 1; k <= 100; k++) begin
      tick();
      ec = (k >= 87) ? 8'd30 : 8'(1 + k / 3);
      ev = (k % 3 == 0) && (k <= 87);
      checks++; if (c2 !== ec) begin failures++; $display("FAIL hold_count k=%0d got=%0d exp=%0d", k, c2, ec); end
      checks++; if (v2 !== ev) begin failures++; $display("FAIL hold_valid k=%0d got=%b exp=%b", k, v2, ev); end
      checks++; if (d2 !== (k >= 87)) begin failures++; $display("FAIL hold_done k=%0d got=%b exp=%b", k, d2, k >= 87); end
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    repeat (48) tick();
    checks++; if (c2 !== 8'd17) begin failures++; $display("FAIL midrst_pre got=%0d exp=17", c2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (c2 !== 8'd1 || v2 !== 1'b0) begin failures++; $display("FAIL midrst_reset got=%0d/%b exp=1/0", c2, v2); end
    tick();
    tick();
    checks++; if (c2 !== 8'd1 || v2 !== 1'b0) begin failures++; $display("FAIL midrst_wait got=%0d/%b exp=1/0", c2, v2); end
    tick();
    checks++; if (c2 !== 8'd2 || v2 !== 1'b1) begin failures++; $display("FAIL midrst_adv got=%0d/%b exp=2/1", c2, v2); end
  endtask

  task automatic test_bcd_wide;
    logic [7:0] ec [13] = '{8'd11, 8'd21, 8'd31, 8'd41, 8'd51, 8'd61, 8'd71, 8'd81, 8'd91, 8'd101, 8'd111, 8'd120, 8'd1};
    logic [3:0] etens [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0};
    logic [3:0] eones [13] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd9, 4'd9, 4'd9, 4'd1};
    logic [3:0] et, eo;
    do_reset();
    for (int k = 0; k < 13; k++) begin
      tick();
`ifdef FILE_WRITE_BCD_EN
      et = etens[k]; eo = eones[k];
`else
      et = 4'd0; eo = 4'd0;
`endif
      checks++; if (c3 !== ec[k]) begin failures++; $display("FAIL bcd_count k=%0d got=%0d exp=%0d", k, c3, ec[k]); end
      checks++; if (t3 !== et || o3 !== eo) begin failures++; $display("FAIL bcd_digits k=%0d got=%0d/%0d exp=%0d/%0d", k, t3, o3, et, eo); end
      checks++; if (d3 !== (k == 12)) begin failures++; $display("FAIL bcd_done k=%0d got=%b exp=%b", k, d3, k == 12); end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_clamp();
    test_hold_prescale();
    test_mid_reset();
    test_bcd_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
